instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the immediate decode path: packs opcode, register fields and a 32-bit
//  immediate into a RV32I instruction word per immediate type (I/S/B/J/U). Checks range
//  and alignment, streams words through a 2-stage valid/ready pipeline and tags each
//  with an instruction-memory word address. Sits between the test/boot loader and IMEM.
// PARAMETERS
//  ADDR_W     8     width of the output word-address counter
//  BASE_ADDR  0     address value loaded at reset and on clear
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  clear      in   1   sync: flush pipeline, reload address, zero err_count
//  in_valid   in   1   input beat valid
//  in_ready   out  1   input accepted when in_valid && in_ready
//  imm_src    in   3   000 I, 001 S, 010 B, 011 J, 100 U; others invalid
//  imm        in   32  byte-offset / value immediate (two's complement)
//  opcode     in   7   placed at [6:0]
//  rd,rs1,rs2 in   5   placed at [11:7],[19:15],[24:20] where the type has them
//  funct3     in   3   placed at [14:12] for I/S/B
//  out_valid  out  1   output beat valid
//  out_ready  in   1   downstream accept
//  out_instr  out  32  packed word (0x00000013 when out_err != 0)
//  out_err    out  2   00 ok, 01 range, 10 misaligned, 11 bad imm_src
//  out_addr   out  ADDR_W  word address of this beat
//  err_count  out  8   saturating count of emitted beats with out_err != 0
// BEHAVIOUR
//  - Reset/clear: out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_count=0,
//    both stage valids 0; in_ready=1 on the cycle after. clear mid-stream drops beats.
//  - Packing: I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op};
//    B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op};
//    J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; U {imm[31:12],rd,op}.
//  - Checks: I/S range if imm[31:11] not all equal; B range if imm[31:12] not all equal,
//    misaligned if imm[0]; J range if imm[31:20] not all equal, misaligned if imm[0];
//    U range if imm[11:0]!=0. Priority: bad type > misaligned > range.
//  - Stage 1 registers fields; stage 2 registers packed word + err. Latency: accept at
//    edge N -> out_valid at edge N+2 with no backpressure. Full throughput 1/cycle.
//  - Stage advances when next stage empty or being consumed; in_ready =
//    !s1_valid || (!s2_valid || out_ready). out_* stable while out_valid && !out_ready.
//  - out_addr increments (mod 2^ADDR_W, wraps) on each output handshake; err beats
//    still consume an address. err_count saturates at 255.
//  - clear and rst dominate same-cycle handshakes; no beat counted that cycle.
// CONFIGURATION
//  ENC_ROUNDTRIP_CHECK_EN defined: stage 2 re-extracts the immediate from the packed
//  word (same rules as the decode-side extender) and compares to the input imm; on a
//  mismatch with out_err==00, assert extra output roundtrip_fail (1b, with the beat).
//  Undefined: no roundtrip_fail port, no re-extraction logic.
// STRUCTURE
//  Shared package: imm_src codes (I_T..U_T), err codes, NOP_INSTR=32'h00000013.
//  One sub-module: imm_pack (combinational pack + check), instantiated in stage 2;
//  pipeline, handshake and counters live in instr_encoder.
// TESTING
//  I addi x1,x0,-1: imm=FFFFFFFF,rd=1,op=13 -> out_instr=FFF00093, err=00, addr=0.
//  B beq +8: imm=8,op=63 -> 00000463; B imm=5 -> err=10, instr=00000013.
//  J jal x1,+2048: imm=800,rd=1,op=6F -> 001000EF; U lui x5: imm=12345000,op=37 -> 123452B7.
//  I imm=2048 -> err=01; imm_src=111 -> err=11; err_count increments each, holds at 255.
//  Backpressure: 3 beats, out_ready low 3 cycles -> in_ready low after 2 accepted,
//    outputs stable, order and addrs 0,1,2 preserved; addr wraps FF->00 at ADDR_W=8.
//  clear with both stages full -> next cycle out_valid=0, out_addr=BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// imm_extract mirrors the decode-side immediate extender (used by ENC_ROUNDTRIP_CHECK_EN).
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    I_T = 3'd0,
    S_T = 3'd1,
    B_T = 3'd2,
    J_T = 3'd3,
    U_T = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    ErrOk       = 2'd0,
    ErrRange    = 2'd1,
    ErrMisalign = 2'd2,
    ErrBadSrc   = 2'd3
  } enc_err_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  imm_src;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
  } enc_fields_t;

  function automatic logic [31:0] imm_extract(logic [2:0] src, logic [31:0] w);
    case (src)
      I_T:     imm_extract = {{20{w[31]}}, w[31:20]};
      S_T:     imm_extract = {{20{w[31]}}, w[31:25], w[11:7]};
      B_T:     imm_extract = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      J_T:     imm_extract = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      U_T:     imm_extract = {w[31:12], 12'b0};
      default: imm_extract = '0;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Input-beat and output-beat handshake bundle of the instruction encoder.
// master = loader/sink side, slave = encoder side.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        imm_src;
  logic [31:0]       imm;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [1:0]        out_err;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, imm_src, imm, opcode, rd, rs1, rs2, funct3, out_ready,
    input  in_ready, out_valid, out_instr, out_err, out_addr
  );

  modport slave (
    input  in_valid, imm_src, imm, opcode, rd, rs1, rs2, funct3, out_ready,
    output in_ready, out_valid, out_instr, out_err, out_addr
  );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational immediate packer and range/alignment checker for one beat.
// ENC_ROUNDTRIP_CHECK_EN adds a decode-side re-extraction cross-check.
module instr_encoder_imm_pack
  import instr_encoder_pkg::*;
(
  input  enc_fields_t f,
  output logic [31:0] instr,
  output enc_err_e    err
`ifdef ENC_ROUNDTRIP_CHECK_EN
  ,
  output logic        roundtrip_fail
`endif
);

  logic [31:0] word;
  logic        rng_is, rng_b, rng_j, rng_u;

  // Immediate fits only if the discarded high bits are a pure sign extension
  assign rng_is = !((&f.imm[31:11]) || !(|f.imm[31:11]));
  assign rng_b  = !((&f.imm[31:12]) || !(|f.imm[31:12]));
  assign rng_j  = !((&f.imm[31:20]) || !(|f.imm[31:20]));
  assign rng_u  = |f.imm[11:0];

  always_comb begin
    word = '0;
    err  = ErrOk;
    case (f.imm_src)
      I_T: begin
        word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
        if (rng_is) err = ErrRange;
      end
      S_T: begin
        word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
        if (rng_is) err = ErrRange;
      end
      B_T: begin
        word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3, f.imm[4:1], f.imm[11],
                f.opcode};
        if (f.imm[0])   err = ErrMisalign;
        else if (rng_b) err = ErrRange;
      end
      J_T: begin
        word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
        if (f.imm[0])   err = ErrMisalign;
        else if (rng_j) err = ErrRange;
      end
      U_T: begin
        word = {f.imm[31:12], f.rd, f.opcode};
        if (rng_u) err = ErrRange;
      end
      default: err = ErrBadSrc;
    endcase
  end

  assign instr = (err == ErrOk) ? word : NOP_INSTR;

`ifdef ENC_ROUNDTRIP_CHECK_EN
  assign roundtrip_fail = (err == ErrOk) && (imm_extract(f.imm_src, word) != f.imm);
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: 2-stage valid/ready pipeline tagging words with IMEM addresses.
// Optional ENC_ROUNDTRIP_CHECK_EN adds the roundtrip_fail output.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  instr_encoder_if.slave        bus,
  output logic [7:0]            err_count
`ifdef ENC_ROUNDTRIP_CHECK_EN
  ,
  output logic                  roundtrip_fail
`endif
);

  logic              s1_valid_q, s2_valid_q;
  enc_fields_t       s1_q, in_fields;
  logic [31:0]       s2_instr_q, pack_instr;
  enc_err_e          s2_err_q, pack_err;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        err_cnt_q;
  logic              s1_ready, s2_ready, out_fire;

  assign in_fields = '{imm_src: bus.imm_src, imm: bus.imm, opcode: bus.opcode, rd: bus.rd,
                       rs1: bus.rs1, rs2: bus.rs2, funct3: bus.funct3};

  assign s2_ready = !s2_valid_q || bus.out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign out_fire = s2_valid_q && bus.out_ready;

`ifdef ENC_ROUNDTRIP_CHECK_EN
  logic pack_rt_fail, rt_fail_q;

  instr_encoder_imm_pack u_imm_pack (
    .f              (s1_q),
    .instr          (pack_instr),
    .err            (pack_err),
    .roundtrip_fail (pack_rt_fail)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rt_fail_q <= 1'b0;
    end else if (s2_ready && s1_valid_q) begin
      rt_fail_q <= pack_rt_fail;
    end
  end

  assign roundtrip_fail = s2_valid_q && rt_fail_q;
`else
  instr_encoder_imm_pack u_imm_pack (
    .f     (s1_q),
    .instr (pack_instr),
    .err   (pack_err)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= ErrOk;
      addr_q     <= BASE_ADDR;
      err_cnt_q  <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) s1_q <= in_fields;
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_instr_q <= pack_instr;
          s2_err_q   <= pack_err;
        end
      end
      // Errored beats still occupy an IMEM slot
      if (out_fire) begin
        addr_q <= addr_q + 1'b1;
        if (s2_err_q != ErrOk && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign bus.in_ready  = s1_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_instr = s2_instr_q;
  assign bus.out_err   = s2_err_q;
  assign bus.out_addr  = addr_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: packing, checks, backpressure,
// address wrap, error-count saturation and clear.
module tb_instr_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [7:0] err_count;
`ifdef ENC_ROUNDTRIP_CHECK_EN
  logic       roundtrip_fail;
`endif

  instr_encoder_if #(.ADDR_W(8)) bus ();

  instr_encoder #(
    .ADDR_W    (8),
    .BASE_ADDR (8'h00)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .bus            (bus),
    .err_count      (err_count)
`ifdef ENC_ROUNDTRIP_CHECK_EN
    ,
    .roundtrip_fail (roundtrip_fail)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_addr = 8'h00;
  int         exp_errcnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic [2:0] src, input logic [31:0] imm, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3);
    bus.imm_src = src;
    bus.imm     = imm;
    bus.opcode  = op;
    bus.rd      = rd;
    bus.rs1     = rs1;
    bus.rs2     = rs2;
    bus.funct3  = f3;
  endtask

  task automatic model_beat(input logic [1:0] err);
    exp_addr = exp_addr + 8'd1;
    if (err != 2'b00 && exp_errcnt < 255) exp_errcnt++;
  endtask

  // One isolated beat: checks latency, packed word, error code, address and err_count
  task automatic send_one(input string tag, input logic [2:0] src, input logic [31:0] imm,
                          input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [31:0] exp_instr, input logic [1:0] exp_err);
    int cyc = 0;
    @(negedge clk);
    drive(src, imm, op, rd, rs1, rs2, f3);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_acc"}, 32'(cyc < 10), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, "_lat2"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_instr"}, bus.out_instr, exp_instr);
    check_eq({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
    check_eq({tag, "_addr"}, 32'(bus.out_addr), 32'(exp_addr));
`ifdef ENC_ROUNDTRIP_CHECK_EN
    check_eq({tag, "_rt"}, 32'(roundtrip_fail), 32'd0);
`endif
    model_beat(exp_err);
    @(negedge clk);
    check_eq({tag, "_cnt"}, 32'(err_count), 32'(exp_errcnt));
  endtask

  initial begin
    int sent, got, cyc;
    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_instr", bus.out_instr, 32'd0);
    check_eq("rst_err", 32'(bus.out_err), 32'd0);
    check_eq("rst_addr", 32'(bus.out_addr), 32'd0);
    check_eq("rst_cnt", 32'(err_count), 32'd0);
    check_eq("rst_inrdy", 32'(bus.in_ready), 32'd1);

    send_one("i_m1",    3'd0, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF0_0093, 2'd0);
    send_one("i_m2048", 3'd0, 32'hFFFF_F800, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'h8000_0013, 2'd0);
    send_one("s_sw",    3'd1, 32'd4,         7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'h0020_A223, 2'd0);
    send_one("b_p8",    3'd2, 32'd8,         7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0463, 2'd0);
    send_one("b_m4",    3'd2, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFE00_0EE3, 2'd0);
    send_one("b_mis",   3'd2, 32'd5,         7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 2'd2);
    send_one("b_prio",  3'd2, 32'h0000_2001, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 2'd2);
    send_one("j_2048",  3'd3, 32'h0000_0800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_00EF, 2'd0);
    send_one("j_mis",   3'd3, 32'd3,         7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 2'd2);
    send_one("j_rng",   3'd3, 32'h0010_0000, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 2'd1);
    send_one("u_lui",   3'd4, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_52B7, 2'd0);
    send_one("u_rng",   3'd4, 32'h1234_5001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 2'd1);
    send_one("i_rng",   3'd0, 32'd2048,      7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 2'd1);
    send_one("bad7",    3'd7, 32'd0,         7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 2'd3);
    send_one("bad6",    3'd6, 32'h0000_2001, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 2'd3);

    // Backpressure: out_ready low while three beats are offered
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(3'd0, 32'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive(3'd0, 32'd2, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
    @(negedge clk);
    drive(3'd0, 32'd3, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_inrdy", 32'(bus.in_ready), 32'd0);
      check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_instr", bus.out_instr, 32'h0010_0093);
      check_eq("bp_addr", 32'(bus.out_addr), 32'(exp_addr));
      if (i < 2) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    model_beat(2'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("bp_instr1", bus.out_instr, 32'h0020_0093);
    check_eq("bp_addr1", 32'(bus.out_addr), 32'(exp_addr));
    model_beat(2'd0);
    @(negedge clk);
    check_eq("bp_instr2", bus.out_instr, 32'h0030_0093);
    check_eq("bp_addr2", 32'(bus.out_addr), 32'(exp_addr));
    model_beat(2'd0);
    @(negedge clk);
    check_eq("bp_drain", 32'(bus.out_valid), 32'd0);

    // Back-to-back bad-src beats: full throughput, address wrap, err_count saturation
    sent = 0;
    got = 0;
    cyc = 0;
    drive(3'd7, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0);
    bus.in_valid = 1'b1;
    while (got < 260 && cyc < 300) begin
      if (bus.out_valid) begin
        check_eq("st_addr", 32'(bus.out_addr), 32'(exp_addr));
        check_eq("st_err", 32'(bus.out_err), 32'd3);
        model_beat(2'd3);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(negedge clk);
      if (sent == 260) bus.in_valid = 1'b0;
      cyc++;
    end
    check_eq("st_done", 32'(got), 32'd260);
    check_eq("st_thru", 32'(cyc <= 262), 32'd1);
    check_eq("st_sat", 32'(err_count), 32'd255);

    // clear with both stages full
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("clr_full", 32'(bus.in_ready), 32'd0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_eq("clr_valid", 32'(bus.out_valid), 32'd0);
    check_eq("clr_addr", 32'(bus.out_addr), 32'd0);
    check_eq("clr_cnt", 32'(err_count), 32'd0);
    check_eq("clr_inrdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check_eq("clr_flushed", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    exp_addr = 8'h00;
    exp_errcnt = 0;
    send_one("post_clr", 3'd0, 32'd7, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 32'h0071_8113, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
